sdram_init_checker: RTL and testbench
=====================================

Name: sdram_init_checker

Overview:
- Passive responder-side monitor on the SDRAM command bus (cs_n/ras_n/cas_n/we_n/addr/ba/cke).
- Decodes each sampled command and checks the power-up init sequence and its inter-command timing: wait, PRECHARGE ALL, N auto-refreshes, LOAD MODE.
- Captures the mode register and reports device-ready.
- Used in simulation and in on-board debug alongside the init/controller logic.

Parameters:
- T_POWERUP, 13300, minimum cycles from reset release to the first non-NOP command (100 us at 133 MHz).
- T_RP, 3, minimum cycle gap from PRECHARGE to the next command.
- T_RC, 9, minimum cycle gap from AUTO_REFRESH to the next command.
- T_MRD, 2, minimum cycle gap from LOAD_MODE to the next command.
- N_REFRESH, 2, minimum AUTO_REFRESH count between PRECHARGE and LOAD_MODE.
- CNT_W, 14, width of the saturating cycle counters.

Ports:
- clk  in  1  clock
- reset_n  in  1  asynchronous active-low reset
- cke  in  1  SDRAM clock enable
- cs_n, ras_n, cas_n, we_n  in  1 each  SDRAM command pins
- addr  in  12  SDRAM address
- ba  in  2  bank address
- err_clear  in  1  synchronous clear of the sticky error flags
- cmd_valid  out  1  pulse: a non-NOP command was decoded on the previous edge
- cmd_code  out  3  decoded command, sdram_pkg encoding
- init_ok  out  1  init sequence completed legally
- mode_reg  out  12  last accepted LOAD_MODE addr value
- cas_latency  out  3  mode_reg[6:4]
- burst_len  out  3  mode_reg[2:0]
- err_early, err_seq, err_trp, err_trc, err_tmrd  out  1 each  sticky violation flags

Behaviour:
- Reset: async, asserted by reset_n low. All outputs are 0, the FSM is in POWERUP, and all counters are 0.
- Sampling: the bus is sampled every rising edge. With cke=0, or cs_n=1, the cycle counts as NOP.
- Decode on {cs_n,ras_n,cas_n,we_n}:
  - 0111 NOP
  - 0011 ACTIVE
  - 0101 READ
  - 0100 WRITE
  - 0110 BST
  - 0010 PRECHARGE
  - 0001 AUTO_REFRESH
  - 0000 LOAD_MODE
- Outputs are registered with 1-cycle latency. cmd_valid/cmd_code appear the cycle after the command edge.
- pu_cnt counts cycles since reset release and saturates at all-ones.
- gap_cnt resets to 1 on the cycle after any non-NOP command, then increments and saturates. The gap for a new command is gap_cnt in the cycle the command is sampled.
- last_cmd records the previous non-NOP command.
- Timing checks, applied to every non-NOP command in any state:
  - pu_cnt < T_POWERUP sets err_early.
  - last_cmd=PRECHARGE and gap < T_RP sets err_trp.
  - last_cmd=AUTO_REFRESH and gap < T_RC sets err_trc.
  - last_cmd=LOAD_MODE and gap < T_MRD sets err_tmrd.
- FSM states: POWERUP, WAIT_PRE, REFRESHING, WAIT_MRS, READY.
  - POWERUP → WAIT_PRE when pu_cnt reaches T_POWERUP.
  - A non-NOP command in POWERUP flags err_early and, if it is PRECHARGE with addr[10]=1, is still accepted (→ REFRESHING).
  - WAIT_PRE: PRECHARGE with addr[10]=1 → REFRESHING, ref_cnt=0. Any other command, including PRECHARGE with addr[10]=0, sets err_seq and the state holds.
  - REFRESHING: each AUTO_REFRESH increments ref_cnt. When ref_cnt reaches N_REFRESH → WAIT_MRS.
    - LOAD_MODE here sets err_seq and is not captured.
    - PRECHARGE here restarts, ref_cnt=0, with no error.
    - Any other command sets err_seq.
  - WAIT_MRS: extra AUTO_REFRESH is allowed and stays in WAIT_MRS. LOAD_MODE captures addr into mode_reg → READY. Any other command sets err_seq.
  - READY: init_ok=1, asserted the cycle after LOAD_MODE. Every command is legal; LOAD_MODE re-captures mode_reg. init_ok stays 1 until reset.
- Simultaneous events:
  - A timing error and a sequence error raised by one command both set their flags.
  - A command that violates timing still advances the FSM if it is sequence-legal.
  - err_clear in the same cycle as a new violation: the set wins.
- Reset mid-sequence returns to POWERUP, and pu_cnt restarts from 0.
- ba is ignored, except that it is captured nowhere. A LOAD_MODE with ba≠0 sets err_seq and is not captured.

Decomposition:
- sdram_pkg holds:
  - the sdram_cmd_t enum (3-bit codes listed above);
  - timing localparams for 133 MHz;
  - mode register field positions (CL 6:4, BT 3, BL 2:0);
  - the init checker state enum.
- The existing init FSM is migrated to sdram_pkg.
- One sub-module, sdram_cmd_decode (combinational pins→sdram_cmd_t incl. cke/cs_n masking), is reused by the future read/write controller.

Test Plan:
- Legal sequence, T_POWERUP=100: PRECHARGE addr=0x400 @cycle 101, AR @105, AR @114, LOAD_MODE addr=0x031 @123 → init_ok=1 @124, mode_reg=0x031, cas_latency=3, burst_len=1, all err=0.
- PRECHARGE @50 with T_POWERUP=100 → err_early=1, state advances, rest of the sequence completes with init_ok=1.
- AR at gap 2 after PRECHARGE → err_trp=1. Second AR at gap 5 after the first → err_trc=1. init_ok still reaches 1.
- LOAD_MODE after only one AR → err_seq=1, mode_reg stays 0, init_ok=0. A second AR plus LOAD_MODE then gives init_ok=1.
- cke=0 during a LOAD_MODE pin pattern in WAIT_MRS → ignored, no cmd_valid. err_clear then clears a prior err_seq; if err_clear coincides with a new violation, the flag stays 1.
- Assert reset_n low in REFRESHING → all outputs 0 immediately. After release, a PRECHARGE at pu_cnt<T_POWERUP sets err_early.

Source files
------------

// File: rtl/sdram_pkg.sv
// Shared SDRAM definitions: command encoding, 133 MHz timing defaults,
// mode register field positions and the init checker state encoding.
package sdram_pkg;

    typedef enum logic [2:0] {
        CMD_NOP          = 3'd0,
        CMD_ACTIVE       = 3'd1,
        CMD_READ         = 3'd2,
        CMD_WRITE        = 3'd3,
        CMD_BST          = 3'd4,
        CMD_PRECHARGE    = 3'd5,
        CMD_AUTO_REFRESH = 3'd6,
        CMD_LOAD_MODE    = 3'd7
    } sdram_cmd_t;

    typedef enum logic [2:0] {
        ST_POWERUP    = 3'd0,
        ST_WAIT_PRE   = 3'd1,
        ST_REFRESHING = 3'd2,
        ST_WAIT_MRS   = 3'd3,
        ST_READY      = 3'd4
    } init_state_t;

    // 133 MHz: 100 us power-up wait, tRP, tRC and tMRD in clock cycles
    localparam int T_POWERUP_133 = 13300;
    localparam int T_RP_133      = 3;
    localparam int T_RC_133      = 9;
    localparam int T_MRD_133     = 2;
    localparam int N_REFRESH_DEF = 2;
    localparam int CNT_W_DEF     = 14;

    localparam int MODE_CL_MSB = 6;
    localparam int MODE_CL_LSB = 4;
    localparam int MODE_BT_BIT = 3;
    localparam int MODE_BL_MSB = 2;
    localparam int MODE_BL_LSB = 0;
    localparam int PRE_ALL_BIT = 10;

endpackage

// File: rtl/sdram_cmd_decode.sv
// Combinational decode of the SDRAM command pins; a deselected chip or a
// low clock enable reads as NOP.
module sdram_cmd_decode
    import sdram_pkg::*;
(
    input  logic       cke_i,
    input  logic       cs_n_i,
    input  logic       ras_n_i,
    input  logic       cas_n_i,
    input  logic       we_n_i,
    output sdram_cmd_t cmd_o
);

    always_comb begin
        cmd_o = CMD_NOP;
        if (cke_i && !cs_n_i) begin
            case ({ras_n_i, cas_n_i, we_n_i})
                3'b011:  cmd_o = CMD_ACTIVE;
                3'b101:  cmd_o = CMD_READ;
                3'b100:  cmd_o = CMD_WRITE;
                3'b110:  cmd_o = CMD_BST;
                3'b010:  cmd_o = CMD_PRECHARGE;
                3'b001:  cmd_o = CMD_AUTO_REFRESH;
                3'b000:  cmd_o = CMD_LOAD_MODE;
                default: cmd_o = CMD_NOP;
            endcase
        end
    end

endmodule

// File: rtl/sdram_init_checker.sv
// Passive monitor of the SDRAM command bus: checks the power-up init sequence
// and its inter-command timing, captures the mode register, reports ready.
module sdram_init_checker
    import sdram_pkg::*;
#(
    parameter int T_POWERUP = T_POWERUP_133,
    parameter int T_RP      = T_RP_133,
    parameter int T_RC      = T_RC_133,
    parameter int T_MRD     = T_MRD_133,
    parameter int N_REFRESH = N_REFRESH_DEF,
    parameter int CNT_W     = CNT_W_DEF
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        cke,
    input  logic        cs_n,
    input  logic        ras_n,
    input  logic        cas_n,
    input  logic        we_n,
    input  logic [11:0] addr,
    input  logic [1:0]  ba,
    input  logic        err_clear,
    output logic        cmd_valid,
    output logic [2:0]  cmd_code,
    output logic        init_ok,
    output logic [11:0] mode_reg,
    output logic [2:0]  cas_latency,
    output logic [2:0]  burst_len,
    output logic        err_early,
    output logic        err_seq,
    output logic        err_trp,
    output logic        err_trc,
    output logic        err_tmrd
);

    localparam int REF_W = (N_REFRESH < 2) ? 1 : $clog2(N_REFRESH + 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [CNT_W-1:0] TPU_C    = CNT_W'(T_POWERUP);
    localparam logic [CNT_W-1:0] TRP_C    = CNT_W'(T_RP);
    localparam logic [CNT_W-1:0] TRC_C    = CNT_W'(T_RC);
    localparam logic [CNT_W-1:0] TMRD_C   = CNT_W'(T_MRD);
    localparam logic [REF_W-1:0] NREF_C   = REF_W'(N_REFRESH);

    sdram_cmd_t  cmd;
    logic        cmdIsValid;
    logic        preAll;
    logic        lmmOk;

    init_state_t state_q, state_d;
    logic [CNT_W-1:0] pu_cnt_q, pu_cnt_d;
    logic [CNT_W-1:0] gap_cnt_q, gap_cnt_d;
    sdram_cmd_t  last_cmd_q, last_cmd_d;
    logic [REF_W-1:0] ref_cnt_q, ref_cnt_d;
    logic [11:0] mode_reg_q, mode_reg_d;
    logic        cmd_valid_q;
    sdram_cmd_t  cmd_code_q;
    logic        init_ok_q;
    logic        err_early_q, err_early_d;
    logic        err_seq_q, err_seq_d;
    logic        err_trp_q, err_trp_d;
    logic        err_trc_q, err_trc_d;
    logic        err_tmrd_q, err_tmrd_d;
    logic        setEarly, setSeq, setTrp, setTrc, setTmrd;

    sdram_cmd_decode u_decode (
        .cke_i   (cke),
        .cs_n_i  (cs_n),
        .ras_n_i (ras_n),
        .cas_n_i (cas_n),
        .we_n_i  (we_n),
        .cmd_o   (cmd)
    );

    assign cmdIsValid = (cmd != CMD_NOP);
    assign preAll     = (cmd == CMD_PRECHARGE) && addr[PRE_ALL_BIT];
    assign lmmOk      = (cmd == CMD_LOAD_MODE) && (ba == 2'b00);

    // Cycle counters and timing checks; the gap seen by a command is the
    // count of edges since the previous non-NOP command.
    always_comb begin
        pu_cnt_d   = (pu_cnt_q == CNT_MAX) ? pu_cnt_q : pu_cnt_q + 1'b1;
        gap_cnt_d  = (gap_cnt_q == CNT_MAX) ? gap_cnt_q : gap_cnt_q + 1'b1;
        last_cmd_d = last_cmd_q;
        setEarly   = 1'b0;
        setTrp     = 1'b0;
        setTrc     = 1'b0;
        setTmrd    = 1'b0;
        if (cmdIsValid) begin
            gap_cnt_d  = CNT_W'(1);
            last_cmd_d = cmd;
            setEarly   = (pu_cnt_q < TPU_C);
            setTrp     = (last_cmd_q == CMD_PRECHARGE)    && (gap_cnt_q < TRP_C);
            setTrc     = (last_cmd_q == CMD_AUTO_REFRESH) && (gap_cnt_q < TRC_C);
            setTmrd    = (last_cmd_q == CMD_LOAD_MODE)    && (gap_cnt_q < TMRD_C);
        end
    end

    // Init sequence FSM; an early PRECHARGE ALL is still accepted so the
    // rest of the sequence can be checked.
    always_comb begin
        state_d    = state_q;
        ref_cnt_d  = ref_cnt_q;
        mode_reg_d = mode_reg_q;
        setSeq     = 1'b0;
        case (state_q)
            ST_POWERUP: begin
                if (preAll) begin
                    state_d   = ST_REFRESHING;
                    ref_cnt_d = '0;
                end else if (pu_cnt_q >= TPU_C) begin
                    state_d = ST_WAIT_PRE;
                    setSeq  = cmdIsValid;
                end
            end
            ST_WAIT_PRE: begin
                if (preAll) begin
                    state_d   = ST_REFRESHING;
                    ref_cnt_d = '0;
                end else begin
                    setSeq = cmdIsValid;
                end
            end
            ST_REFRESHING: begin
                if (cmd == CMD_AUTO_REFRESH) begin
                    ref_cnt_d = ref_cnt_q + 1'b1;
                    if (ref_cnt_q + 1'b1 >= NREF_C) begin
                        state_d = ST_WAIT_MRS;
                    end
                end else if (cmd == CMD_PRECHARGE) begin
                    ref_cnt_d = '0;
                end else begin
                    setSeq = cmdIsValid;
                end
            end
            ST_WAIT_MRS: begin
                if (lmmOk) begin
                    mode_reg_d = addr;
                    state_d    = ST_READY;
                end else if (cmd != CMD_AUTO_REFRESH) begin
                    setSeq = cmdIsValid;
                end
            end
            ST_READY: begin
                if (lmmOk) begin
                    mode_reg_d = addr;
                end else if (cmd == CMD_LOAD_MODE) begin
                    setSeq = 1'b1;
                end
            end
            default: state_d = ST_POWERUP;
        endcase
    end

    // A new violation wins over a simultaneous clear.
    always_comb begin
        err_early_d = (err_clear ? 1'b0 : err_early_q) | setEarly;
        err_seq_d   = (err_clear ? 1'b0 : err_seq_q)   | setSeq;
        err_trp_d   = (err_clear ? 1'b0 : err_trp_q)   | setTrp;
        err_trc_d   = (err_clear ? 1'b0 : err_trc_q)   | setTrc;
        err_tmrd_d  = (err_clear ? 1'b0 : err_tmrd_q)  | setTmrd;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_POWERUP;
            pu_cnt_q    <= '0;
            gap_cnt_q   <= '0;
            last_cmd_q  <= CMD_NOP;
            ref_cnt_q   <= '0;
            mode_reg_q  <= '0;
            cmd_valid_q <= 1'b0;
            cmd_code_q  <= CMD_NOP;
            init_ok_q   <= 1'b0;
            err_early_q <= 1'b0;
            err_seq_q   <= 1'b0;
            err_trp_q   <= 1'b0;
            err_trc_q   <= 1'b0;
            err_tmrd_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            pu_cnt_q    <= pu_cnt_d;
            gap_cnt_q   <= gap_cnt_d;
            last_cmd_q  <= last_cmd_d;
            ref_cnt_q   <= ref_cnt_d;
            mode_reg_q  <= mode_reg_d;
            cmd_valid_q <= cmdIsValid;
            cmd_code_q  <= cmd;
            init_ok_q   <= (state_d == ST_READY);
            err_early_q <= err_early_d;
            err_seq_q   <= err_seq_d;
            err_trp_q   <= err_trp_d;
            err_trc_q   <= err_trc_d;
            err_tmrd_q  <= err_tmrd_d;
        end
    end

    assign cmd_valid   = cmd_valid_q;
    assign cmd_code    = cmd_code_q;
    assign init_ok     = init_ok_q;
    assign mode_reg    = mode_reg_q;
    assign cas_latency = mode_reg_q[MODE_CL_MSB:MODE_CL_LSB];
    assign burst_len   = mode_reg_q[MODE_BL_MSB:MODE_BL_LSB];
    assign err_early   = err_early_q;
    assign err_seq     = err_seq_q;
    assign err_trp     = err_trp_q;
    assign err_trc     = err_trc_q;
    assign err_tmrd    = err_tmrd_q;

endmodule

// File: tb/tb_sdram_init_checker.sv
// Directed and randomized bench for sdram_init_checker, checked against a
// command-history model of the init rules.
module tb_sdram_init_checker;
    import sdram_pkg::*;

    localparam int TPU   = 100;
    localparam int TRP   = 3;
    localparam int TRC   = 9;
    localparam int TMRD  = 2;
    localparam int NREF  = 2;
    localparam int SATMX = 16383;

    logic        clk = 1'b0;
    logic        reset_n = 1'b1;
    logic        cke = 1'b0;
    logic        cs_n = 1'b1;
    logic        ras_n = 1'b1;
    logic        cas_n = 1'b1;
    logic        we_n = 1'b1;
    logic [11:0] addr = '0;
    logic [1:0]  ba = '0;
    logic        err_clear = 1'b0;
    logic        cmd_valid;
    logic [2:0]  cmd_code;
    logic        init_ok;
    logic [11:0] mode_reg;
    logic [2:0]  cas_latency;
    logic [2:0]  burst_len;
    logic        err_early, err_seq, err_trp, err_trc, err_tmrd;

    int testCount = 0;
    int failCount = 0;

    // Model: elapsed edges since reset release and the history of commands.
    int          cycleNow;
    sdram_cmd_t  mLast;
    int          mLastCycle;
    bit          mPreDone;
    int          mRefs;
    bit          mLoaded;
    logic [11:0] mMode;
    bit          eEarly, eSeq, eTrp, eTrc, eTmrd;
    bit          expValid;
    sdram_cmd_t  expCode;

    sdram_init_checker #(
        .T_POWERUP (TPU),
        .T_RP      (TRP),
        .T_RC      (TRC),
        .T_MRD     (TMRD),
        .N_REFRESH (NREF),
        .CNT_W     (14)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .cke         (cke),
        .cs_n        (cs_n),
        .ras_n       (ras_n),
        .cas_n       (cas_n),
        .we_n        (we_n),
        .addr        (addr),
        .ba          (ba),
        .err_clear   (err_clear),
        .cmd_valid   (cmd_valid),
        .cmd_code    (cmd_code),
        .init_ok     (init_ok),
        .mode_reg    (mode_reg),
        .cas_latency (cas_latency),
        .burst_len   (burst_len),
        .err_early   (err_early),
        .err_seq     (err_seq),
        .err_trp     (err_trp),
        .err_trc     (err_trc),
        .err_tmrd    (err_tmrd)
    );

    always #5 clk = ~clk;

    function automatic logic [3:0] pinsOf(input sdram_cmd_t c);
        case (c)
            CMD_ACTIVE:       return 4'b0011;
            CMD_READ:         return 4'b0101;
            CMD_WRITE:        return 4'b0100;
            CMD_BST:          return 4'b0110;
            CMD_PRECHARGE:    return 4'b0010;
            CMD_AUTO_REFRESH: return 4'b0001;
            CMD_LOAD_MODE:    return 4'b0000;
            default:          return 4'b0111;
        endcase
    endfunction

    task automatic check1(input string tag, input logic [11:0] obs, input logic [11:0] exp);
        testCount++;
        assert (obs === exp) else begin
            failCount++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic checkOutput();
        check1("cmd_valid",   12'(cmd_valid),   12'(expValid));
        check1("cmd_code",    12'(cmd_code),    12'(expCode));
        check1("init_ok",     12'(init_ok),     12'(mLoaded));
        check1("mode_reg",    mode_reg,         mMode);
        check1("cas_latency", 12'(cas_latency), 12'(mMode[6:4]));
        check1("burst_len",   12'(burst_len),   12'(mMode[2:0]));
        check1("err_early",   12'(err_early),   12'(eEarly));
        check1("err_seq",     12'(err_seq),     12'(eSeq));
        check1("err_trp",     12'(err_trp),     12'(eTrp));
        check1("err_trc",     12'(err_trc),     12'(eTrc));
        check1("err_tmrd",    12'(err_tmrd),    12'(eTmrd));
    endtask

    task automatic modelReset();
        cycleNow = 0;  mLast = CMD_NOP;  mLastCycle = 0;
        mPreDone = 0;  mRefs = 0;  mLoaded = 0;  mMode = '0;
        eEarly = 0;  eSeq = 0;  eTrp = 0;  eTrc = 0;  eTmrd = 0;
        expValid = 0;  expCode = CMD_NOP;
    endtask

    task automatic modelStep(input sdram_cmd_t c, input logic [11:0] a,
                             input logic [1:0] b, input bit clr);
        bit sE, sS, sP, sC, sM;
        int pu, gap;
        sE = 0;  sS = 0;  sP = 0;  sC = 0;  sM = 0;
        pu = (cycleNow > SATMX) ? SATMX : cycleNow;
        expValid = (c != CMD_NOP);
        expCode  = c;
        if (expValid) begin
            gap = cycleNow - mLastCycle;
            sE = (pu < TPU);
            sP = (mLast == CMD_PRECHARGE)    && (gap < TRP);
            sC = (mLast == CMD_AUTO_REFRESH) && (gap < TRC);
            sM = (mLast == CMD_LOAD_MODE)    && (gap < TMRD);
            if (mLoaded) begin
                if (c == CMD_LOAD_MODE) begin
                    if (b == 2'b00) mMode = a;
                    else sS = 1;
                end
            end else if (!mPreDone) begin
                if (c == CMD_PRECHARGE && a[10]) begin
                    mPreDone = 1;  mRefs = 0;
                end else if (pu >= TPU) begin
                    sS = 1;
                end
            end else if (mRefs < NREF) begin
                if (c == CMD_AUTO_REFRESH) mRefs++;
                else if (c == CMD_PRECHARGE) mRefs = 0;
                else sS = 1;
            end else begin
                if (c == CMD_LOAD_MODE && b == 2'b00) begin
                    mMode = a;  mLoaded = 1;
                end else if (c != CMD_AUTO_REFRESH) begin
                    sS = 1;
                end
            end
            mLast = c;
            mLastCycle = cycleNow;
        end
        eEarly = (clr ? 1'b0 : eEarly) | sE;
        eSeq   = (clr ? 1'b0 : eSeq)   | sS;
        eTrp   = (clr ? 1'b0 : eTrp)   | sP;
        eTrc   = (clr ? 1'b0 : eTrc)   | sC;
        eTmrd  = (clr ? 1'b0 : eTmrd)  | sM;
        cycleNow++;
    endtask

    task automatic applyStimulus(input sdram_cmd_t c, input logic [11:0] a, input logic [1:0] b,
                                 input bit ckeOn, input bit desel, input bit clr);
        logic [3:0] p;
        p = pinsOf(c);
        cke = ckeOn;  cs_n = desel ? 1'b1 : p[3];
        ras_n = p[2];  cas_n = p[1];  we_n = p[0];
        addr = a;  ba = b;  err_clear = clr;
        @(posedge clk);
        modelStep((ckeOn && !desel) ? c : CMD_NOP, a, b, clr);
        #1;
        checkOutput();
    endtask

    task automatic issue(input sdram_cmd_t c, input logic [11:0] a, input logic [1:0] b);
        applyStimulus(c, a, b, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(CMD_NOP, 12'h000, 2'b00, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic doReset();
        reset_n = 1'b0;
        cke = 1'b0;  cs_n = 1'b1;  err_clear = 1'b0;
        #1;
        modelReset();
        checkOutput();
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    // Legal PRE / AR / AR then LOAD_MODE, with the first command after TPU.
    task automatic legalTail(input logic [11:0] mode);
        idle(3);   issue(CMD_AUTO_REFRESH, 12'h000, 2'b00);
        idle(8);   issue(CMD_AUTO_REFRESH, 12'h000, 2'b00);
        idle(8);   issue(CMD_LOAD_MODE, mode, 2'b00);
    endtask

    initial begin
        logic [11:0] ra;
        logic [1:0]  rb;
        sdram_cmd_t  rc;
        #2;
        doReset();

        // Legal sequence: PRE at pu=100, AR +4, AR +9, LOAD_MODE +9.
        idle(TPU);
        issue(CMD_PRECHARGE, 12'h400, 2'b00);
        legalTail(12'h031);
        idle(1);
        check1("legal_init_ok", 12'(init_ok), 12'h001);
        check1("legal_mode",    mode_reg,     12'h031);
        check1("legal_cl",      12'(cas_latency), 12'h003);
        check1("legal_bl",      12'(burst_len),   12'h001);
        check1("legal_errs",    12'({err_early, err_seq, err_trp, err_trc, err_tmrd}), 12'h000);

        // Early PRECHARGE still advances the sequence.
        doReset();
        idle(49);
        issue(CMD_PRECHARGE, 12'h400, 2'b00);
        check1("early_flag", 12'(err_early), 12'h001);
        legalTail(12'h022);
        idle(1);
        check1("early_init_ok", 12'(init_ok), 12'h001);

        // tRP and tRC violations, sequence still completes.
        doReset();
        idle(TPU);
        issue(CMD_PRECHARGE, 12'h400, 2'b00);
        idle(1);  issue(CMD_AUTO_REFRESH, 12'h000, 2'b00);
        check1("trp_flag", 12'(err_trp), 12'h001);
        idle(4);  issue(CMD_AUTO_REFRESH, 12'h000, 2'b00);
        check1("trc_flag", 12'(err_trc), 12'h001);
        idle(8);  issue(CMD_LOAD_MODE, 12'h032, 2'b00);
        idle(1);
        check1("trc_init_ok", 12'(init_ok), 12'h001);

        // LOAD_MODE after one AR is rejected; a second AR then completes it.
        doReset();
        idle(TPU);
        issue(CMD_PRECHARGE, 12'h400, 2'b00);
        idle(3);  issue(CMD_AUTO_REFRESH, 12'h000, 2'b00);
        idle(8);  issue(CMD_LOAD_MODE, 12'h031, 2'b00);
        check1("seq_flag",    12'(err_seq),  12'h001);
        check1("seq_mode",    mode_reg,      12'h000);
        check1("seq_init_ok", 12'(init_ok),  12'h000);
        idle(8);  issue(CMD_AUTO_REFRESH, 12'h000, 2'b00);
        idle(8);  issue(CMD_LOAD_MODE, 12'h031, 2'b00);
        idle(1);
        check1("seq_recover", 12'(init_ok), 12'h001);

        // cke masking, err_clear, and clear colliding with a new violation.
        doReset();
        idle(TPU);
        issue(CMD_PRECHARGE, 12'h400, 2'b00);
        idle(3);  issue(CMD_AUTO_REFRESH, 12'h000, 2'b00);
        idle(8);  issue(CMD_AUTO_REFRESH, 12'h000, 2'b00);
        idle(8);  issue(CMD_ACTIVE, 12'h000, 2'b00);
        check1("mrs_active_seq", 12'(err_seq), 12'h001);
        idle(3);
        applyStimulus(CMD_LOAD_MODE, 12'h031, 2'b00, 1'b0, 1'b0, 1'b0);
        check1("cke_masked", 12'(cmd_valid), 12'h000);
        applyStimulus(CMD_LOAD_MODE, 12'h031, 2'b00, 1'b1, 1'b1, 1'b0);
        applyStimulus(CMD_NOP, 12'h000, 2'b00, 1'b1, 1'b0, 1'b1);
        check1("clear_seq", 12'(err_seq), 12'h000);
        idle(2);
        applyStimulus(CMD_READ, 12'h000, 2'b00, 1'b1, 1'b0, 1'b1);
        check1("clear_vs_set", 12'(err_seq), 12'h001);
        idle(3);  issue(CMD_LOAD_MODE, 12'h020, 2'b01);
        idle(3);  issue(CMD_LOAD_MODE, 12'h020, 2'b00);
        idle(1);  issue(CMD_LOAD_MODE, 12'h052, 2'b00);
        idle(2);

        // Reset in REFRESHING, then an early PRECHARGE.
        doReset();
        idle(TPU);
        issue(CMD_PRECHARGE, 12'h400, 2'b00);
        idle(3);  issue(CMD_AUTO_REFRESH, 12'h000, 2'b00);
        idle(2);
        doReset();
        idle(20);
        issue(CMD_PRECHARGE, 12'h400, 2'b00);
        check1("reset_early", 12'(err_early), 12'h001);

        // Randomized command streams against the model.
        for (int s = 0; s < 3; s++) begin
            doReset();
            idle(TPU - 5 + $urandom_range(0, 10));
            for (int k = 0; k < 50; k++) begin
                ra = 12'($urandom);
                rb = 2'b00;
                case ($urandom_range(0, 9))
                    0, 1, 2: begin rc = CMD_PRECHARGE;  ra[10] = ($urandom_range(0, 3) != 0); end
                    3, 4, 5: rc = CMD_AUTO_REFRESH;
                    6, 7: begin
                        rc = CMD_LOAD_MODE;
                        if ($urandom_range(0, 3) == 0) rb = 2'($urandom);
                    end
                    8: rc = sdram_cmd_t'(3'($urandom_range(1, 4)));
                    default: rc = CMD_NOP;
                endcase
                applyStimulus(rc, ra, rb, ($urandom_range(0, 9) != 0),
                              ($urandom_range(0, 9) == 0), ($urandom_range(0, 7) == 0));
                idle($urandom_range(0, 11));
            end
        end

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule
